// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: arbiter state type and grant-index width helper
package fifo_arb_pkg;
  typedef enum logic {IDLE, GRANT} state_t;
  function automatic int id_width(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: first set req bit at or above ptr, wrapping (req,ptr -> found,idx)
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  localparam int IW = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic               found,
  output logic [IW-1:0]      idx
);
  logic [IW-1:0] j;
  always_comb begin
    found = 1'b0;
    idx = '0;
    j = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      j = IW'((int'(ptr) + i) % NUM_REQ);
      if (req[j]) begin
        found = 1'b1;
        idx = j;
      end
    end
  end
endmodule

// File: rtl/async_fifo_wr_arbiter.sv
// async_fifo_wr_arbiter: round-robin burst arbiter of NUM_REQ valid/ready streams onto one FIFO write port (wclk,wrst; req_* in, req_ready/fifo_wen/fifo_wdata/grant_*/err_overflow out)
module async_fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST = 4,
  localparam int IW = id_width(NUM_REQ),
  localparam int BW = $clog2(MAX_BURST + 1)
) (
  input  logic                          wclk,
  input  logic                          wrst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          fifo_wen,
  output logic [DATA_WIDTH-1:0]         fifo_wdata,
  input  logic                          fifo_full,
  input  logic                          fifo_overflow,
  output logic                          grant_valid,
  output logic [IW-1:0]                 grant_id,
  output logic                          err_overflow
);
  state_t state, state_n;
  logic [IW-1:0] gid_n, prio_ptr, ptr_n, idx, nxt;
  logic [BW-1:0] beat_cnt, cnt_n;
  logic found, xfer, rel, arb;
  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req(req_valid),
    .ptr(prio_ptr),
    .found(found),
    .idx(idx)
  );
  assign grant_valid = state == GRANT;
  assign xfer = grant_valid & req_valid[grant_id] & ~fifo_full & ~wrst;
  assign req_ready = xfer ? NUM_REQ'(1) << grant_id : '0;
  assign fifo_wen = xfer;
  assign fifo_wdata = grant_valid ? req_data[grant_id*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign rel = (xfer & (req_last[grant_id] | beat_cnt == BW'(MAX_BURST - 1))) | ~req_valid[grant_id];
  assign nxt = idx == IW'(NUM_REQ - 1) ? '0 : idx + 1'b1;
  always_comb begin
    arb = grant_valid ? rel : 1'b1;
    state_n = arb ? (found ? GRANT : IDLE) : state;
    gid_n = arb & found ? idx : grant_id;
    ptr_n = arb & found ? nxt : prio_ptr;
    cnt_n = arb ? '0 : xfer ? beat_cnt + 1'b1 : beat_cnt;
  end
  always_ff @(posedge wclk) begin
    if (wrst) begin
      state <= IDLE;
      grant_id <= '0;
      beat_cnt <= '0;
      prio_ptr <= '0;
      err_overflow <= 1'b0;
    end else begin
      state <= state_n;
      grant_id <= gid_n;
      beat_cnt <= cnt_n;
      prio_ptr <= ptr_n;
      err_overflow <= err_overflow | fifo_overflow;
    end
  end
endmodule
